// File: rtl/oled_spi_receiver_if.sv
// Signal bundle between an SSD1306-style SPI master and the receiver's byte stream consumer.
// The slave modport is the receiver's view; the master modport drives pins, clears and pops.
interface oled_spi_receiver_if;
    logic        sclk_i;
    logic        sdin_i;
    logic        dc_i;
    logic        cs_i;
    logic        res_i;
    logic        clr_i;
    logic [7:0]  rx_data;
    logic        rx_dc;
    logic        rx_valid;
    logic        rx_ready;
    logic        overflow;
    logic        frame_err;
    logic [15:0] byte_count;

    modport slave (
        input  sclk_i, sdin_i, dc_i, cs_i, res_i, clr_i, rx_ready,
        output rx_data, rx_dc, rx_valid, overflow, frame_err, byte_count
    );

    modport master (
        output sclk_i, sdin_i, dc_i, cs_i, res_i, clr_i, rx_ready,
        input  rx_data, rx_dc, rx_valid, overflow, frame_err, byte_count
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// Oversampling SPI byte receiver for an OLED panel bus, with sticky error flags and a byte counter.
// Define OLED_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO; otherwise a single holding register.
//
//   state | meaning
//   IDLE  | chip select high (or panel reset); SCLK edges ignored
//   SHIFT | chip select low; sampling SDIN on each SCLK rising edge
module oled_spi_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    oled_spi_receiver_if.slave   bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  sclk_sync;
    logic [1:0]  sdin_sync;
    logic [1:0]  dc_sync;
    logic [1:0]  cs_sync;
    logic [1:0]  res_sync;
    logic        sclk_prev;

    logic        sclk_s;
    logic        sdin_s;
    logic        dc_s;
    logic        cs_s;
    logic        res_s;
    logic        sclk_rise;

    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        push_pend;
    logic [8:0]  push_byte;

    logic        do_shift;
    logic        clr_shift;
    logic        set_ferr;

    logic        full;
    logic        pop;
    logic        push_ok;
    logic        ovf_set;
    logic        store_valid;
    logic [8:0]  head;

    logic        overflow;
    logic        frame_err;
    logic [15:0] byte_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            sdin_sync <= 2'b00;
            dc_sync   <= 2'b00;
            cs_sync   <= 2'b11;
            res_sync  <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk_i};
            sdin_sync <= {sdin_sync[0], bus.sdin_i};
            dc_sync   <= {dc_sync[0], bus.dc_i};
            cs_sync   <= {cs_sync[0], bus.cs_i};
            res_sync  <= {res_sync[0], bus.res_i};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign sdin_s    = sdin_sync[1];
    assign dc_s      = dc_sync[1];
    assign cs_s      = cs_sync[1];
    assign res_s     = res_sync[1];
    assign sclk_rise = sclk_s && !sclk_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Panel reset overrides everything and never counts as a framing error.
    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        clr_shift  = 1'b0;
        set_ferr   = 1'b0;
        if (!res_s) begin
            state_next = IDLE;
            clr_shift  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state_next = IDLE;
                        clr_shift  = 1'b1;
                        set_ferr   = (bit_cnt != 3'd0);
                    end else if (sclk_rise) begin
                        do_shift = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The completed byte is staged for one cycle before it reaches the store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            push_pend <= 1'b0;
            push_byte <= 9'h000;
        end else begin
            push_pend <= 1'b0;
            if (clr_shift) begin
                shreg   <= 8'h00;
                bit_cnt <= 3'd0;
            end else if (do_shift) begin
                shreg   <= {shreg[6:0], sdin_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    push_pend <= 1'b1;
                    push_byte <= {dc_s, shreg[6:0], sdin_s};
                end
            end
        end
    end

    assign pop     = store_valid && bus.rx_ready;
    assign push_ok = push_pend && res_s && (!full || pop);
    assign ovf_set = push_pend && res_s && full && !pop;

`ifdef OLED_RX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    assign full        = (count == FULL_CNT);
    assign store_valid = (count != '0);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'h000;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (!res_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'h000;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // When full, a simultaneous pop frees the slot the push overwrites.
            if (push_ok) begin
                mem[wr_ptr] <= push_byte;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end
`else
    localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;

    logic [8:0] hold;
    logic       hold_valid;

    assign full        = hold_valid && (DEPTH == 1);
    assign store_valid = hold_valid;
    assign head        = hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= 9'h000;
            hold_valid <= 1'b0;
        end else if (!res_s) begin
            hold       <= 9'h000;
            hold_valid <= 1'b0;
        end else if (push_ok) begin
            hold       <= push_byte;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // A set event in the same cycle as clr_i takes priority for the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            byte_count <= 16'h0000;
        end else begin
            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (bus.clr_i) begin
                frame_err <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.clr_i) begin
                overflow <= 1'b0;
            end
            if (bus.clr_i) begin
                byte_count <= push_ok ? 16'h0001 : 16'h0000;
            end else if (push_ok) begin
                byte_count <= byte_count + 16'h0001;
            end
        end
    end

    assign bus.rx_data    = head[7:0];
    assign bus.rx_dc      = head[8];
    assign bus.rx_valid   = store_valid;
    assign bus.overflow   = overflow;
    assign bus.frame_err  = frame_err;
    assign bus.byte_count = byte_count;

endmodule

// File: doc/oled_spi_receiver.md
OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16); used only when OLED_RX_FIFO_EN is defined.
REQ-002 SHALL have port clk  input  1  system clock, 27 MHz; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sclk_i  input  1  SPI clock from the OLED master (D0); asynchronous to clk.
REQ-005 SHALL have port sdin_i  input  1  SPI data (D1), MSB first, valid at SCLK rising edge.
REQ-006 SHALL have port dc_i  input  1  data/command select: low = command, high = pixel data.
REQ-007 SHALL have port cs_i  input  1  chip select, active low.
REQ-008 SHALL have port res_i  input  1  OLED reset line, active low.
REQ-009 SHALL have port clr_i  input  1  one-cycle pulse clearing the sticky flags and byte_count.
REQ-010 SHALL have port rx_data  output  8  received byte at the output head.
REQ-011 SHALL have port rx_dc  output  1  dc_i value captured with rx_data.
REQ-012 SHALL have port rx_valid  output  1  rx_data/rx_dc hold a byte.
REQ-013 SHALL have port rx_ready  input  1  consumer accepts; a byte is popped on a cycle where rx_valid && rx_ready.
REQ-014 SHALL have port overflow  output  1  sticky: a completed byte was dropped.
REQ-015 SHALL have port frame_err  output  1  sticky: CS deasserted with 1..7 bits shifted.
REQ-016 SHALL have port byte_count  output  16  completed bytes accepted; wraps 0xFFFF -> 0x0000.

Function
REQ-017 SHALL pass sclk_i, sdin_i, dc_i, cs_i and res_i through two-flop synchronizers before any use.
REQ-018 SHALL detect an SCLK rising edge as synchronized SCLK high while its previous-cycle registered value is low.
REQ-019 SHALL implement states IDLE and SHIFT: IDLE -> SHIFT when synchronized CS is low; SHIFT -> IDLE when synchronized CS is high.
REQ-020 SHALL, in SHIFT, on each SCLK rising edge, shift synchronized SDIN into the LSB of an 8-bit register and increment a 3-bit bit counter.
REQ-021 SHALL, on the 8th edge, form the byte, capture synchronized DC with it, push it, reset the bit counter to 0, and stay in SHIFT for back-to-back bytes.
REQ-022 SHALL make rx_valid rise exactly 4 clk cycles after the 8th SCLK rising edge at the pin when the output is empty (2 sync + 1 edge register + 1 push).
REQ-023 SHALL, on SHIFT -> IDLE with bit counter 1..7, discard the partial byte, clear the counter and set frame_err; counter 0 sets nothing.
REQ-024 SHALL ignore SCLK edges while in IDLE.
REQ-025 SHALL, while synchronized res_i is low, hold IDLE, clear the shift register, bit counter and all stored bytes; flags and byte_count are unaffected.
REQ-026 SHALL, when a push meets a full store with no pop that cycle, drop the new byte, set overflow, and leave byte_count unchanged.
REQ-027 SHALL accept a push and a pop in the same cycle when full; no overflow.
REQ-028 SHALL increment byte_count by 1 for every accepted push.
REQ-029 SHALL, on clr_i, clear overflow, frame_err and byte_count; a same-cycle set event wins for the flags, and a same-cycle push leaves byte_count at 1.
REQ-030 SHALL hold rx_data and rx_dc stable while rx_valid && !rx_ready.
REQ-031 SHALL operate correctly for SCLK high and low phases each >= 3 clk periods; shorter phases are unsupported.

Reset
REQ-032 SHALL, on reset, asynchronously set: state IDLE, shift register 0, bit counter 0, store empty, rx_valid 0, rx_data 0x00, rx_dc 0, overflow 0, frame_err 0, byte_count 0, synchronizers to idle levels (sclk 0, cs 1, res 1, sdin 0, dc 0).
REQ-033 SHALL, on reset mid-byte, discard the partial byte without setting frame_err.

Configuration
REQ-034 SHALL, with OLED_RX_FIFO_EN defined, buffer bytes in a FIFO_DEPTH-entry FIFO (9 bits wide: data + dc), with rx_data/rx_dc driven from its head.
REQ-035 SHALL, without OLED_RX_FIFO_EN, use a single holding register (depth 1); FIFO_DEPTH is ignored and REQ-026/027 apply at depth 1.

Verification
REQ-036 SHALL cover: CS low, DC low, shift 0xAF -> rx_valid 4 cycles after the 8th edge, rx_data 0xAF, rx_dc 0, byte_count 1.
REQ-037 SHALL cover: DC high, bytes 0x55, 0xAA, 0x0F, 0xF0 back-to-back, rx_ready high -> four pops in order, all rx_dc 1, byte_count 4.
REQ-038 SHALL cover: CS high after 5 bits of 0x12 -> no byte, frame_err 1; then clr_i -> frame_err 0, byte_count 0.
REQ-039 SHALL cover: rx_ready low, FIFO_DEPTH+1 bytes with macro (2 bytes without) -> last byte dropped, overflow 1, byte_count = depth.
REQ-040 SHALL cover: res_i low for 10 cycles mid-byte with 2 bytes stored -> rx_valid 0, then the next full byte 0x3C is received correctly.
